// File: rtl/half_adder_checker.sv
// -----------------------------------------------------------------------------
// half_adder_checker
//
// Purpose:
//   Online checker for a 1-bit half adder. After a start request it watches
//   NUM_VECTORS valid samples of {a, b, sum, c_out}, compares sum/c_out
//   against a^b / a&b, counts samples and mismatches, records which input
//   combinations were exercised, and raises pass when the run was clean and
//   fully covered.
//
// Parameters:
//   NUM_VECTORS - samples per run (1 .. 2**CNT_W-1)
//   CNT_W       - width of vec_cnt / err_cnt
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   one-cycle run request (honoured in IDLE/DONE only)
//   in_valid   in   a/b/sum/c_out carry a sample this cycle
//   a, b       in   operands applied to the half adder under test
//   sum, c_out in   responses of the half adder under test
//   busy       out  FSM in RUN
//   done       out  FSM in DONE
//   pass       out  DONE with no errors and full coverage
//   vec_cnt    out  samples checked in current/last run
//   err_cnt    out  mismatching samples, saturating
//   cov        out  bit {a,b} set once that combination was sampled
//   fail_valid out  first mismatch captured     (HA_CHECK_CAPTURE_EN only)
//   fail_vec   out  {a,b,sum,c_out} of it       (HA_CHECK_CAPTURE_EN only)
//
// Build option:
//   HA_CHECK_CAPTURE_EN - when defined, adds first-failure capture ports.
// -----------------------------------------------------------------------------
module half_adder_checker #(
   parameter int unsigned NUM_VECTORS = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   input  logic             sum,
   input  logic             c_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [3:0]       cov
`ifdef HA_CHECK_CAPTURE_EN
   ,
   output logic             fail_valid,
   output logic [3:0]       fail_vec
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] LP_NUM = CNT_W'(NUM_VECTORS);
   localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

   logic [1:0]       r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [CNT_W-1:0] r_vec_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [3:0]       r_cov;

   logic [1:0]       w_state_d;
   logic             w_pass_d;
   logic [CNT_W-1:0] w_vec_d;
   logic [CNT_W-1:0] w_err_d;
   logic [3:0]       w_cov_d;

   logic             w_exp_sum;
   logic             w_exp_c;
   logic             w_mismatch;
   logic [1:0]       w_ab;
   logic [3:0]       w_ab_onehot;
   logic [CNT_W-1:0] w_vec_inc;

`ifdef HA_CHECK_CAPTURE_EN
   logic             r_fail_valid;
   logic [3:0]       r_fail_vec;
   logic             w_fail_valid_d;
   logic [3:0]       w_fail_vec_d;
`endif

   assign w_exp_sum   = a ^ b;
   assign w_exp_c     = a & b;
   assign w_mismatch  = (sum != w_exp_sum) || (c_out != w_exp_c);
   assign w_ab        = {a, b};
   assign w_ab_onehot = 4'b0001 << w_ab;
   assign w_vec_inc   = r_vec_cnt + LP_ONE;

   always_comb begin
      w_state_d = r_state;
      w_vec_d   = r_vec_cnt;
      w_err_d   = r_err_cnt;
      w_cov_d   = r_cov;
`ifdef HA_CHECK_CAPTURE_EN
      w_fail_valid_d = r_fail_valid;
      w_fail_vec_d   = r_fail_vec;
`endif
      case (r_state)
         ST_IDLE, ST_DONE: begin
            // Samples arriving with the accepted start are dropped.
            if (start) begin
               w_state_d = ST_RUN;
               w_vec_d   = '0;
               w_err_d   = '0;
               w_cov_d   = 4'h0;
`ifdef HA_CHECK_CAPTURE_EN
               w_fail_valid_d = 1'b0;
`endif
            end
         end
         ST_RUN: begin
            if (in_valid) begin
               w_vec_d = w_vec_inc;
               w_cov_d = r_cov | w_ab_onehot;
               if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}})) begin
                  w_err_d = r_err_cnt + LP_ONE;
               end
`ifdef HA_CHECK_CAPTURE_EN
               if (w_mismatch && !r_fail_valid) begin
                  w_fail_valid_d = 1'b1;
                  w_fail_vec_d   = {a, b, sum, c_out};
               end
`endif
               if (w_vec_inc == LP_NUM) begin
                  w_state_d = ST_DONE;
               end
            end
         end
         default: w_state_d = ST_IDLE;
      endcase
      w_pass_d = (w_state_d == ST_DONE) && (w_err_d == '0) && (w_cov_d == 4'hF);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_vec_cnt <= '0;
         r_err_cnt <= '0;
         r_cov     <= 4'h0;
      end else begin
         r_state   <= w_state_d;
         r_busy    <= (w_state_d == ST_RUN);
         r_done    <= (w_state_d == ST_DONE);
         r_pass    <= w_pass_d;
         r_vec_cnt <= w_vec_d;
         r_err_cnt <= w_err_d;
         r_cov     <= w_cov_d;
      end
   end

`ifdef HA_CHECK_CAPTURE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fail_valid <= 1'b0;
         r_fail_vec   <= 4'h0;
      end else begin
         r_fail_valid <= w_fail_valid_d;
         r_fail_vec   <= w_fail_vec_d;
      end
   end

   assign fail_valid = r_fail_valid;
   assign fail_vec   = r_fail_vec;
`endif

   assign busy    = r_busy;
   assign done    = r_done;
   assign pass    = r_pass;
   assign vec_cnt = r_vec_cnt;
   assign err_cnt = r_err_cnt;
   assign cov     = r_cov;

endmodule

// File: doc/half_adder_checker.md
HALF_ADDER_CHECKER -- requirements
Module: half_adder_checker

Interface
REQ-001 The block SHALL have parameter NUM_VECTORS, default 4, meaning the number of samples per check run (legal range 1..2^CNT_W-1).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the vector and error counters.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising clock edge.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to begin a run.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the a, b, sum and c_out inputs carry one sample this cycle.
REQ-008 The block SHALL have ports a and b, input, 1 bit each: the operands applied to the half adder under test.
REQ-009 The block SHALL have ports sum and c_out, input, 1 bit each: the responses of the half adder under test.
REQ-010 The block SHALL have port busy, output, 1 bit: the FSM is in RUN.
REQ-011 The block SHALL have port done, output, 1 bit: the FSM is in DONE.
REQ-012 The block SHALL have port pass, output, 1 bit: the completed run had no errors and full coverage.
REQ-013 The block SHALL have port vec_cnt, output, CNT_W bits: samples checked in the current or last run.
REQ-014 The block SHALL have port err_cnt, output, CNT_W bits: mismatching samples (saturating).
REQ-015 The block SHALL have port cov, output, 4 bits: bit {a,b} is set once that input combination has been sampled.
REQ-016 The block SHALL have ports fail_valid (output, 1 bit) and fail_vec (output, 4 bits, {a,b,sum,c_out}) only when HA_CHECK_CAPTURE_EN is defined.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL move the FSM to RUN on the next edge and clear vec_cnt, err_cnt, cov and fail_valid on that same edge.
REQ-019 In RUN, start SHALL be ignored.
REQ-020 in_valid SHALL be ignored in IDLE and DONE, and in the cycle that start is accepted.
REQ-021 In RUN with in_valid=1, the block SHALL compute the expected values exp_sum=a^b and exp_c=a&b.
REQ-022 For each such RUN sample, vec_cnt SHALL increment by 1 and cov[{a,b}] SHALL be set.
REQ-023 For each such RUN sample, err_cnt SHALL increment when sum!=exp_sum or c_out!=exp_c, saturating at all-ones.
REQ-024 All outputs SHALL be registered, so the effect of a sample is visible in the cycle after it is sampled.
REQ-025 The sample that brings vec_cnt to NUM_VECTORS SHALL move the FSM to DONE on the same edge, so done is high the next cycle.
REQ-026 Samples presented after that edge SHALL have no effect.
REQ-027 pass SHALL equal done && err_cnt==0 && cov==4'hF; pass SHALL be 0 whenever not in DONE.
REQ-028 DONE SHALL hold, with vec_cnt, err_cnt and cov frozen, until start or rst.
REQ-029 A sample with in_valid=0 in RUN SHALL change no state; there is no timeout.

Reset
REQ-030 rst SHALL take priority over start and in_valid in any state, including mid-run.
REQ-031 On rst, the FSM SHALL go to IDLE and busy, done, pass, vec_cnt, err_cnt, cov, fail_valid and fail_vec SHALL all be 0 from the next cycle.

Configuration
REQ-032 With HA_CHECK_CAPTURE_EN defined, the first mismatching sample of a run SHALL load fail_vec={a,b,sum,c_out} and set fail_valid.
REQ-033 With HA_CHECK_CAPTURE_EN defined, later mismatches SHALL NOT overwrite fail_vec, and fail_valid SHALL clear on start acceptance or rst.
REQ-034 With HA_CHECK_CAPTURE_EN undefined, the fail_valid and fail_vec ports and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-035 Bench SHALL check: start, then four correct samples (ab=00,01,10,11 with matching sum/c_out) -> done=1, pass=1, vec_cnt=4, err_cnt=0, cov=4'hF.
REQ-036 Bench SHALL check: run with sample a=1,b=1,sum=1,c_out=1 -> err_cnt=1, pass=0; with the macro defined, fail_vec=4'b1111 and fail_valid=1.
REQ-037 Bench SHALL check: four correct samples all ab=00 -> done=1, cov=4'b0001, pass=0.
REQ-038 Bench SHALL check: CNT_W=2 with NUM_VECTORS=3 and every sample wrong -> err_cnt=3 (saturated at all-ones), and a fourth sample after DONE changes nothing.
REQ-039 Bench SHALL check: rst asserted after two samples -> next cycle busy=0, vec_cnt=0, cov=0; a following start and four samples give the correct result.
REQ-040 Bench SHALL check: start pulsed mid-RUN and in_valid pulsed in IDLE -> both ignored, and counters match only the RUN samples.
